// File: rtl/emu_clock_gen.sv
// Emulated clock generator: advances this clock's next-edge time on each matching event and
// drives round-robin one-hot clock enables. Optional EMU_CLOCK_STATS_EN adds an event counter.
module emu_clock_gen #(
    parameter int N_PHASES    = 1,
    parameter int TIME_WIDTH  = 32,
    parameter int INC_BITS    = 16,
    parameter int DEFAULT_INC = 1,
    localparam int PW         = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  run,
    input  logic [TIME_WIDTH-1:0] time_next,
    input  logic                  inc_valid,
    input  logic [INC_BITS-1:0]   inc,
    output logic                  inc_ready,
    output logic [TIME_WIDTH-1:0] time_clock,
    output logic                  time_eq,
    output logic [N_PHASES-1:0]   clk_en,
    output logic [PW-1:0]         phase_idx,
    output logic                  missed,
    output logic [31:0]           edge_count
);

    localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

    logic                  pend_full;
    logic [INC_BITS-1:0]   pend_val;
    logic [INC_BITS-1:0]   last_inc;
    logic [INC_BITS-1:0]   chosen_inc;
    logic [INC_BITS-1:0]   applied_inc;
    logic [TIME_WIDTH-1:0] time_diff;
    logic                  miss_now;
    logic                  xfer;

    always_comb begin
        time_eq     = run && (time_next == time_clock);
        inc_ready   = !rst && (!pend_full || time_eq);
        xfer        = inc_valid && inc_ready;
        chosen_inc  = pend_full ? pend_val : last_inc;
        // a zero increment would freeze emulated time, so it is promoted to 1
        applied_inc = (chosen_inc == '0) ? INC_BITS'(1) : chosen_inc;
        time_diff   = time_next - time_clock;
        miss_now    = run && !time_diff[TIME_WIDTH-1] && (time_diff != '0);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            time_clock <= '0;
            phase_idx  <= '0;
            clk_en     <= '0;
            missed     <= 1'b0;
            pend_full  <= 1'b0;
            pend_val   <= '0;
            last_inc   <= INC_BITS'(DEFAULT_INC);
        end else begin
            clk_en <= time_eq ? (N_PHASES'(1) << phase_idx) : '0;
            if (miss_now)
                missed <= 1'b1;
            if (time_eq) begin
                time_clock <= time_clock + TIME_WIDTH'(applied_inc);
                last_inc   <= applied_inc;
                phase_idx  <= (phase_idx == LAST_PHASE) ? '0 : phase_idx + 1'b1;
            end
            // the event consumes the old buffered value before a same-cycle transfer refills it
            if (xfer) begin
                pend_full <= 1'b1;
                pend_val  <= inc;
            end else if (time_eq) begin
                pend_full <= 1'b0;
            end
        end
    end

`ifdef EMU_CLOCK_STATS_EN
    logic [31:0] event_cnt;

    always_ff @(posedge clk_sys) begin
        if (rst)
            event_cnt <= '0;
        else if (time_eq && (event_cnt != 32'hFFFF_FFFF))
            event_cnt <= event_cnt + 32'd1;
    end

    assign edge_count = event_cnt;
`else
    assign edge_count = '0;
`endif

endmodule

// File: tb/tb_emu_clock_gen.sv
// Bench for emu_clock_gen: directed scenarios then randomized cycles, checked against a
// cycle-level reference model with a queue-based increment buffer.
module tb_emu_clock_gen;

    localparam int NP = 3;
    localparam int DEF_INC = 5;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  time_next = '0;
    logic        inc_valid = 1'b0;
    logic [7:0]  inc = '0;
    logic        inc_ready;
    logic [7:0]  time_clock;
    logic        time_eq;
    logic [2:0]  clk_en;
    logic [1:0]  phase_idx;
    logic        missed;
    logic [31:0] edge_count;

    emu_clock_gen #(
        .N_PHASES(NP), .TIME_WIDTH(8), .INC_BITS(8), .DEFAULT_INC(DEF_INC)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .run(run), .time_next(time_next),
        .inc_valid(inc_valid), .inc(inc), .inc_ready(inc_ready),
        .time_clock(time_clock), .time_eq(time_eq), .clk_en(clk_en),
        .phase_idx(phase_idx), .missed(missed), .edge_count(edge_count)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad = 0;

    int          m_time = 0;
    int          m_phase = 0;
    int          m_last = DEF_INC;
    int          m_pq[$];
    int          m_clk_en = 0;
    bit          m_missed = 1'b0;
    longint      m_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit rn, input int tn, input bit v, input int iv);
        bit ev;
        bit rdy;
        int d;
        int a;
        rst = r; run = rn; time_next = 8'(tn); inc_valid = v; inc = 8'(iv);
        #1;
        ev  = rn && ((tn & 255) == m_time);
        rdy = !r && ((m_pq.size() == 0) || ev);
        chk("time_eq", {31'd0, time_eq}, {31'd0, ev});
        chk("inc_ready", {31'd0, inc_ready}, {31'd0, rdy});
        @(posedge clk_sys);
        if (r) begin
            m_time = 0; m_phase = 0; m_clk_en = 0; m_missed = 0; m_count = 0;
            m_pq.delete(); m_last = DEF_INC;
        end else begin
            d = ((tn & 255) - m_time + 256) % 256;
            if (rn && d >= 1 && d <= 127) m_missed = 1;
            m_clk_en = ev ? (1 << m_phase) : 0;
            if (ev) begin
                a = (m_pq.size() != 0) ? m_pq.pop_front() : m_last;
                if (a == 0) a = 1;
                m_last = a;
                m_time = (m_time + a) % 256;
                m_phase = (m_phase + 1) % NP;
                if (m_count < 64'hFFFF_FFFF) m_count++;
            end
            if (v && rdy) m_pq.push_back(iv & 255);
        end
        #1;
        chk("time_clock", {24'd0, time_clock}, 32'(m_time));
        chk("phase_idx", {30'd0, phase_idx}, 32'(m_phase));
        chk("clk_en", {29'd0, clk_en}, 32'(m_clk_en));
        chk("missed", {31'd0, missed}, {31'd0, m_missed});
`ifdef EMU_CLOCK_STATS_EN
        chk("edge_count", edge_count, 32'(m_count));
`else
        chk("edge_count", edge_count, 32'd0);
`endif
    endtask

    initial begin
        int sel;
        int tn;
        @(posedge clk_sys);
        #1;
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 3);
        // follow time_clock: 0,5,10,15 with phases 0,1,2,0
        for (int i = 0; i < 4; i++) step(0, 1, m_time, 0, 0);
        // buffer 7 off-event, then offer 9 in the event that consumes 7
        step(0, 1, m_time - 1, 1, 7);
        step(0, 1, m_time, 1, 9);
        step(0, 1, m_time, 0, 0);
        step(0, 1, m_time, 0, 0);
        // zero increment promotes to 1
        step(0, 1, m_time - 1, 1, 0);
        step(0, 1, m_time, 0, 0);
        step(0, 1, m_time, 0, 0);
        // larger increment to drive the 8-bit time through its wrap
        step(0, 1, m_time - 1, 1, 60);
        for (int i = 0; i < 8; i++) step(0, 1, m_time, 0, 0);
        // run low holds state while the handshake still works
        step(0, 0, m_time, 1, 2);
        step(0, 0, m_time + 3, 1, 4);
        // miss detection and stickiness
        step(0, 1, m_time + 3, 0, 0);
        step(0, 1, m_time - 2, 0, 0);
        step(0, 1, m_time, 0, 0);
        // reset during an event with a handshake; no enable pulse afterwards
        step(1, 1, m_time, 1, 4);
        step(0, 0, m_time, 0, 0);
        step(0, 1, m_time, 0, 0);
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) tn = m_time;
            else if (sel < 8) tn = m_time - $urandom_range(1, 100);
            else tn = $urandom_range(0, 255);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, tn,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 12));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/emu_clock_gen.md
EMU_CLOCK_GEN -- requirements
Module: emu_clock_gen

Interface
REQ-001 The block SHALL have parameter N_PHASES, default 1, giving the number of round-robin clock-enable phases; legal range 1..8.
REQ-002 The block SHALL have parameter TIME_WIDTH, default 32, giving the emulated-time word width.
REQ-003 The block SHALL have parameter INC_BITS, default 16, giving the period-increment width.
REQ-004 The block SHALL have parameter DEFAULT_INC, default 1, giving the increment used until the first increment is loaded.
REQ-005 clk_sys  input  1  system clock; all logic is on its rising edge; one clock; reset is synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 run  input  1  event enable; when low, no clock event occurs.
REQ-008 time_next  input  TIME_WIDTH  global next-event time, the minimum over all emulated clocks.
REQ-009 inc_valid  input  1  a new period increment is offered.
REQ-010 inc  input  INC_BITS  period increment value.
REQ-011 inc_ready  output  1  the block accepts inc this cycle.
REQ-012 time_clock  output  TIME_WIDTH  this clock's next edge time (registered).
REQ-013 time_eq  output  1  combinational event flag: run & (time_next == time_clock).
REQ-014 clk_en  output  N_PHASES  registered one-hot phase enables, intended for external clock gates.
REQ-015 phase_idx  output  clog2(N_PHASES), minimum 1 bit  phase that the next event fires.
REQ-016 missed  output  1  sticky flag: an event was skipped.
REQ-017 edge_count  output  32  number of events since reset.

Function
REQ-018 An event SHALL be a clk_sys cycle in which time_eq=1.
REQ-019 On an event, time_clock SHALL become (time_clock + applied increment) mod 2^TIME_WIDTH, with the increment zero-extended.
REQ-020 The applied increment SHALL come from a one-deep pending buffer.
- If the buffer is full, use its value and clear it.
- Otherwise reuse last_inc.
- The applied value SHALL be written to last_inc.
REQ-021 An applied increment of 0 SHALL be treated as 1, so that time cannot stall.
REQ-022 inc_ready SHALL equal (~pending_full | time_eq).
- A transfer occurs when inc_valid & inc_ready.
- On a transfer in the same cycle as an event that consumes the old pending value, the new value SHALL land in the buffer, not in that event.
- On a transfer into an empty buffer in an event cycle, the new value SHALL be buffered for the next event; last_inc is applied now.
REQ-023 clk_en SHALL equal the one-hot decode of phase_idx, registered, in the cycle after an event, and SHALL be 0 in all other cycles; latency is exactly 1 clk_sys cycle.
REQ-024 phase_idx SHALL advance by 1 on each event and wrap from N_PHASES-1 to 0; when N_PHASES=1 it stays 0.
REQ-025 missed SHALL set when run=1 and the signed difference (time_next - time_clock) is greater than 0.
- missed SHALL stay set until rst.
- Detecting a miss SHALL NOT by itself change time_clock.
REQ-026 When run=0:
- time_clock, phase_idx and last_inc SHALL hold.
- The inc handshake SHALL still operate.
- No miss SHALL be detected.

Reset
REQ-027 On rst=1 at a clk_sys edge, the following SHALL take these values:
- time_clock=0, phase_idx=0, clk_en=0, missed=0, edge_count=0.
- pending buffer empty, last_inc=DEFAULT_INC.
REQ-028 rst SHALL override a simultaneous event and handshake.
- A pending increment is dropped.
- A clk_en pulse due in the following cycle SHALL be suppressed.
REQ-029 While rst=1, inc_ready SHALL be 0.

Configuration
REQ-030 Macro EMU_CLOCK_STATS_EN, when defined, SHALL compile in a 32-bit edge_count counter.
- It increments on each event and saturates at 2^32-1.
- When the macro is undefined, edge_count SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-031 N_PHASES=1, DEFAULT_INC=5, run=1, time_next follows time_clock -> time_clock sequence 0,5,10,15; clk_en[0] pulses 1 cycle after each match.
REQ-032 N_PHASES=3, increment 4 -> clk_en cycles through 001,010,100,001; phase_idx sequence 0,1,2,0.
REQ-033 Load inc=7 while pending is empty, then load inc=9 in the next event cycle -> increments applied in order 7, then 9, with no value lost; inc_ready stays 1.
REQ-034 TIME_WIDTH=8, time_clock=250, inc=10 -> wraps to 4; missed stays 0 when time_next=4.
REQ-035 Drive time_next=time_clock+3 -> missed rises and stays set; then assert rst mid-event -> all outputs return to their reset values and no clk_en pulse follows.
REQ-036 inc=0 loaded -> the next event advances time_clock by 1; with EMU_CLOCK_STATS_EN defined, edge_count equals the number of events; with it undefined, edge_count=0.
